// File: rtl/ui_uart_pkg.sv
// ---------------------------------------------------------------------------
// ui_uart_pkg
// Shared definitions for the ui_uart_rx serial receiver.
//   - rx_state_t : receiver FSM states
//   - DATA_BITS  : payload bits per frame
//   - cnt_width  : width of a down-counter that must hold values up to n-1
// Optional feature macro used by the receiver: UI_UART_RX_PARITY_EN
// ---------------------------------------------------------------------------
package ui_uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rx_state_t;

   // Bits needed to hold a count of 0 .. n-1 (at least one bit).
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ui_uart_rx_if.sv
// ---------------------------------------------------------------------------
// ui_uart_rx_if
// Byte stream from the receiver to the core.
//   m_data  : head-of-FIFO byte
//   m_valid : a byte is available
//   m_ready : consumer accepts m_data when m_valid & m_ready
// Modports: master (receiver side), slave (consumer side).
// ---------------------------------------------------------------------------
interface ui_uart_rx_if;
   import ui_uart_pkg::*;

   logic [DATA_BITS-1:0] m_data;
   logic                 m_valid;
   logic                 m_ready;

   modport master (output m_data, output m_valid, input m_ready);
   modport slave  (input m_data, input m_valid, output m_ready);

endinterface

// File: rtl/ui_byte_fifo.sv
// ---------------------------------------------------------------------------
// ui_byte_fifo
// Small synchronous FIFO with show-ahead head output.
//   clk, rst   : clock, synchronous active-high reset (empties FIFO, clears storage)
//   push, din  : write request and data (ignored when full unless popping too)
//   pop        : read request (ignored when empty)
//   dout       : head entry
//   full/empty : status
//   count      : entries held
// A push while full is accepted when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module ui_byte_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count_reg == (AW+1)'(DEPTH));
   assign empty = (count_reg == '0);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign dout  = mem_reg[rd_ptr_reg];
   assign count = count_reg;

   // Storage is cleared on reset so the head output reads 0 out of reset.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (rst)
               mem_reg[gi] <= '0;
            else if (wr_en && (wr_ptr_reg == AW'(gi)))
               mem_reg[gi] <= din;
         end
      end
   endgenerate

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/ui_uart_rx.sv
// ---------------------------------------------------------------------------
// ui_uart_rx
// Oversampling 8N1 serial receiver feeding a byte FIFO and a valid/ready stream.
//   clk, rst   : clock, synchronous active-high reset
//   ena        : receiver runs when high; low holds FSM in IDLE (FIFO/flags kept)
//   rx_i       : raw serial input, idle high, asynchronous
//   m          : ui_uart_rx_if.master byte stream (m_data, m_valid, m_ready)
//   frame_err  : one-cycle pulse on bad stop bit (or bad parity)
//   overflow   : sticky, byte dropped on full FIFO; cleared by clr_err
//   clr_err    : clears overflow, wins over a same-cycle new overflow
//   fifo_count : entries held in the FIFO
// Macro UI_UART_RX_PARITY_EN: when defined the frame is 8E1 with a parity check.
// ---------------------------------------------------------------------------
module ui_uart_rx
   import ui_uart_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ena,
   input  logic                          rx_i,
   ui_uart_rx_if.master                  m,
   output logic                          frame_err,
   output logic                          overflow,
   input  logic                          clr_err,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int            CW   = cnt_width(CLK_DIV);
   localparam logic [CW-1:0] HALF = CW'(CLK_DIV/2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);

   logic                 sync1_reg;
   logic                 rx_s_reg;
   rx_state_t            state_reg;
   logic [CW-1:0]        cnt_reg;
   logic [2:0]           bit_idx_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 frame_err_reg;
   logic                 overflow_reg;
`ifdef UI_UART_RX_PARITY_EN
   logic                 par_bad_reg;
`endif

   logic cnt_zero;
   logic push;
   logic pop;
   logic full;
   logic empty;

   // Two-flop synchronizer, preset to the idle line level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg <= 1'b1;
         rx_s_reg  <= 1'b1;
      end else begin
         sync1_reg <= rx_i;
         rx_s_reg  <= sync1_reg;
      end
   end

   assign cnt_zero = (cnt_reg == '0);

   // Push is decoded in the stop-bit sample cycle so m_valid rises one cycle later.
`ifdef UI_UART_RX_PARITY_EN
   assign push = ena && (state_reg == STOP) && cnt_zero && rx_s_reg && !par_bad_reg;
`else
   assign push = ena && (state_reg == STOP) && cnt_zero && rx_s_reg;
`endif
   assign pop  = m.m_valid && m.m_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         bit_idx_reg   <= '0;
         shift_reg     <= '0;
         frame_err_reg <= 1'b0;
`ifdef UI_UART_RX_PARITY_EN
         par_bad_reg   <= 1'b0;
`endif
      end else begin
         frame_err_reg <= 1'b0;
         if (!ena) begin
            state_reg <= IDLE;
         end else begin
            case (state_reg)
               IDLE: begin
                  // First sample point lands mid start bit.
                  if (!rx_s_reg) begin
                     cnt_reg   <= HALF;
                     state_reg <= START;
                  end
               end
               START: begin
                  if (cnt_zero) begin
                     if (rx_s_reg) begin
                        state_reg <= IDLE;
                     end else begin
                        cnt_reg     <= FULL;
                        bit_idx_reg <= '0;
                        state_reg   <= DATA;
                     end
                  end else begin
                     cnt_reg <= cnt_reg - CW'(1);
                  end
               end
               DATA: begin
                  if (cnt_zero) begin
                     shift_reg   <= {rx_s_reg, shift_reg[DATA_BITS-1:1]};
                     cnt_reg     <= FULL;
                     bit_idx_reg <= bit_idx_reg + 3'd1;
                     if (bit_idx_reg == 3'(DATA_BITS-1)) begin
`ifdef UI_UART_RX_PARITY_EN
                        state_reg <= PARITY;
`else
                        state_reg <= STOP;
`endif
                     end
                  end else begin
                     cnt_reg <= cnt_reg - CW'(1);
                  end
               end
`ifdef UI_UART_RX_PARITY_EN
               PARITY: begin
                  // Even parity: data XOR parity bit must be zero.
                  if (cnt_zero) begin
                     par_bad_reg <= (^shift_reg) ^ rx_s_reg;
                     cnt_reg     <= FULL;
                     state_reg   <= STOP;
                  end else begin
                     cnt_reg <= cnt_reg - CW'(1);
                  end
               end
`endif
               STOP: begin
                  if (cnt_zero) begin
                     if (rx_s_reg) begin
`ifdef UI_UART_RX_PARITY_EN
                        frame_err_reg <= par_bad_reg;
`endif
                        state_reg <= IDLE;
                     end else begin
                        frame_err_reg <= 1'b1;
                        state_reg     <= BREAK;
                     end
                  end else begin
                     cnt_reg <= cnt_reg - CW'(1);
                  end
               end
               BREAK: begin
                  if (rx_s_reg) state_reg <= IDLE;
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

   // Sticky overflow: a byte is lost only when full and nothing leaves this cycle.
   always_ff @(posedge clk) begin
      if (rst)
         overflow_reg <= 1'b0;
      else if (clr_err)
         overflow_reg <= 1'b0;
      else if (push && full && !pop)
         overflow_reg <= 1'b1;
   end

   ui_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_BITS)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (shift_reg),
      .pop   (pop),
      .dout  (m.m_data),
      .full  (full),
      .empty (empty),
      .count (fifo_count)
   );

   assign m.m_valid = !empty;
   assign frame_err = frame_err_reg;
   assign overflow  = overflow_reg;

endmodule
